// File: rtl/opb_register_bank_simulink2ppc.sv
// ---------------------------------------------------------------------------
// opb_register_bank_simulink2ppc
//
// Multi-channel readback bank for the OPB bus. C_NUM_CH 32-bit user-fabric
// words are captured into shadow registers in one atomic snapshot, so that
// software reads a coherent set. A snapshot is taken by a software command
// (CTRL write) or by an auto-capture timer running every C_AUTO_PERIOD cycles.
//
// Word map (offset from C_BASEADDR, in 32-bit words):
//   0        CTRL/STATUS  write: LSB = snapshot request, next bit = auto_en
//                                (honoured only when OPB_BE[3] is set)
//                         read : upper 16 bits = snap_cnt, bit 1 = auto_en
//   1        timestamp of the last snapshot (zero unless the timestamp
//            counter is built)
//   2+i      shadow of channel i, read-only (writes acked and dropped)
//   others   read as zero, acked
//
// Ports:
//   OPB_Clk, OPB_Rst_n   clock and asynchronous active-low reset
//   OPB_ABus/BE/DBus     OPB address, byte enables, write data (bit 0 = MSB)
//   OPB_RNW/select       transfer direction and request
//   OPB_seqAddr          ignored
//   Sl_DBus              read data, zero outside a read acknowledge
//   Sl_xferAck           one-cycle acknowledge, the cycle after the hit
//   Sl_errAck/retry/toutSup  tied low
//   user_data_in         channel i at bits [32i+31:32i], synchronous to OPB_Clk
//
// Build option: define REG_BANK_TIMESTAMP_EN to build a 32-bit free-running
// cycle counter that is captured at every snapshot and read at offset 1.
// ---------------------------------------------------------------------------
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR    = 32'h0108_0100,
    parameter logic [31:0] C_HIGHADDR    = 32'h0108_01FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_CH      = 4,
    parameter int          C_AUTO_PERIOD = 1024,
    parameter string       C_FAMILY      = "virtex5"
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    input  logic [C_NUM_CH*32-1:0]    user_data_in
);

    localparam int                  AW       = C_OPB_AWIDTH;
    localparam int                  OFF_W    = C_OPB_AWIDTH - 2;
    localparam int                  PER_W    = $clog2(C_AUTO_PERIOD);
    localparam logic [AW-1:0]       BASE     = AW'(C_BASEADDR);
    localparam logic [AW-1:0]       HIGH     = AW'(C_HIGHADDR);
    localparam logic [PER_W-1:0]    PER_LAST = PER_W'(C_AUTO_PERIOD - 1);
    localparam bit                  FAMILY_SET = (C_FAMILY != "");

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Bus decode. The [0:N] ports are re-viewed as ordinary [N:0] vectors so
    // that numeric bit 0 is the OPB LSB (OPB bit 31).
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_rel;
    logic [31:0]   dbus;
    logic          hit;

    assign addr     = OPB_ABus;
    assign dbus     = OPB_DBus;
    assign addr_rel = addr - BASE;
    assign hit      = OPB_select && (addr >= BASE) && (addr <= HIGH);

    // Slave FSM and latched transfer attributes
    state_e            state_q, state_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              rnw_q, rnw_d;
    logic              be3_q, be3_d;
    logic              wr_snap_q, wr_snap_d;
    logic              wr_auto_q, wr_auto_d;

    // Capture datapath
    logic [31:0]       shadow_q [C_NUM_CH];
    logic [31:0]       shadow_d [C_NUM_CH];
    logic [15:0]       snap_cnt_q, snap_cnt_d;
    logic              auto_en_q, auto_en_d;
    logic [PER_W-1:0]  period_q, period_d;

    logic              ctrl_wr;
    logic              snap_sw;
    logic              snap_auto;
    logic              snap;
    logic [31:0]       rd_data;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        off_d     = off_q;
        rnw_d     = rnw_q;
        be3_d     = be3_q;
        wr_snap_d = wr_snap_q;
        wr_auto_d = wr_auto_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d   = ST_ACK;
                    off_d     = addr_rel[AW-1:2];
                    rnw_d     = OPB_RNW;
                    be3_d     = OPB_BE[3];
                    wr_snap_d = dbus[0];
                    wr_auto_d = dbus[1];
                end
            end
            ST_ACK:  state_d = ST_WAIT;
            // Hold off a new transfer until the master drops select, so a
            // select held across the ack is not decoded as a second hit.
            ST_WAIT: if (!OPB_select) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A CTRL write takes effect in its ACK cycle; the shadows and auto_en
    // show the new values from the following cycle.
    assign ctrl_wr   = (state_q == ST_ACK) && !rnw_q && (off_q == '0) && be3_q;
    assign snap_sw   = ctrl_wr && wr_snap_q;
    assign snap_auto = auto_en_q && (period_q == PER_LAST);
    // Coincident software and timer requests merge into one snapshot.
    assign snap      = snap_sw || snap_auto;

    always_comb begin
        auto_en_d  = ctrl_wr ? wr_auto_q : auto_en_q;
        snap_cnt_d = snap ? snap_cnt_q + 16'd1 : snap_cnt_q;
        // The period counter parks at zero while auto mode is off, so turning
        // it on always begins a full interval.
        period_d   = '0;
        if (auto_en_q && (period_q != PER_LAST)) begin
            period_d = period_q + PER_W'(1);
        end
        for (int i = 0; i < C_NUM_CH; i++) begin
            shadow_d[i] = snap ? user_data_in[32*i +: 32] : shadow_q[i];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q    <= ST_IDLE;
            off_q      <= '0;
            rnw_q      <= 1'b0;
            be3_q      <= 1'b0;
            wr_snap_q  <= 1'b0;
            wr_auto_q  <= 1'b0;
            snap_cnt_q <= '0;
            auto_en_q  <= 1'b0;
            period_q   <= '0;
            // NOTE: the shadow array is reset element by element; software may
            // read it before the first snapshot and must see zeros, so it is
            // kept as flops rather than an unreset RAM.
            for (int i = 0; i < C_NUM_CH; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            rnw_q      <= rnw_d;
            be3_q      <= be3_d;
            wr_snap_q  <= wr_snap_d;
            wr_auto_q  <= wr_auto_d;
            snap_cnt_q <= snap_cnt_d;
            auto_en_q  <= auto_en_d;
            period_q   <= period_d;
            for (int i = 0; i < C_NUM_CH; i++) begin
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

`ifdef REG_BANK_TIMESTAMP_EN
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic [31:0] ts_shadow_q, ts_shadow_d;

    always_comb begin
        ts_cnt_d    = ts_cnt_q + 32'd1;
        ts_shadow_d = snap ? ts_cnt_q : ts_shadow_q;
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            ts_cnt_q    <= '0;
            ts_shadow_q <= '0;
        end else begin
            ts_cnt_q    <= ts_cnt_d;
            ts_shadow_q <= ts_shadow_d;
        end
    end
`endif

    // Read mux works on the registered state, so a read acked in the same
    // cycle as a snapshot returns the pre-snapshot contents.
    always_comb begin
        rd_data = '0;
        if (off_q == '0) begin
            rd_data = {snap_cnt_q, 14'd0, auto_en_q, 1'b0};
        end
`ifdef REG_BANK_TIMESTAMP_EN
        if (off_q == OFF_W'(1)) begin
            rd_data = ts_shadow_q;
        end
`endif
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (off_q == OFF_W'(2 + i)) begin
                rd_data = shadow_q[i];
            end
        end
    end

    assign Sl_xferAck = (state_q == ST_ACK);
    assign Sl_DBus    = (state_q == ST_ACK && rnw_q) ? rd_data : '0;
    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;

    // Inputs and address bits that carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{OPB_seqAddr, OPB_BE[0:2], dbus[31:2], addr_rel[1:0], FAMILY_SET};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// ---------------------------------------------------------------------------
// Self-checking bench for opb_register_bank_simulink2ppc.
// A cycle-level reference model (arrays + arithmetic) tracks snapshots,
// snap_cnt, auto mode and the timestamp; bus reads are compared against it.
// ---------------------------------------------------------------------------
module tb_opb_register_bank_simulink2ppc;

    localparam int          NUM_CH = 4;
    localparam int          PERIOD = 8;
    localparam logic [31:0] BASE   = 32'h0108_0100;
    localparam logic [31:0] HIGH   = 32'h0108_01FF;

    logic                clk         = 1'b0;
    logic                rst_n       = 1'b0;
    logic [0:31]         opb_abus    = '0;
    logic [0:3]          opb_be      = '0;
    logic [0:31]         opb_dbus    = '0;
    logic                opb_rnw     = 1'b1;
    logic                opb_select  = 1'b0;
    logic                opb_seqaddr = 1'b0;
    logic [0:31]         sl_dbus;
    logic                sl_xferack;
    logic                sl_errack;
    logic                sl_retry;
    logic                sl_toutsup;
    logic [NUM_CH*32-1:0] user_data  = '0;

    always #5 clk = ~clk;

    opb_register_bank_simulink2ppc #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_CH     (NUM_CH),
        .C_AUTO_PERIOD(PERIOD),
        .C_FAMILY     ("virtex5")
    ) dut (
        .OPB_Clk     (clk),
        .OPB_Rst_n   (rst_n),
        .OPB_ABus    (opb_abus),
        .OPB_BE      (opb_be),
        .OPB_DBus    (opb_dbus),
        .OPB_RNW     (opb_rnw),
        .OPB_select  (opb_select),
        .OPB_seqAddr (opb_seqaddr),
        .Sl_DBus     (sl_dbus),
        .Sl_xferAck  (sl_xferack),
        .Sl_errAck   (sl_errack),
        .Sl_retry    (sl_retry),
        .Sl_toutSup  (sl_toutsup),
        .user_data_in(user_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_shadow [NUM_CH];
    logic [15:0] m_snap_cnt;
    bit          m_auto_en;
    int          m_age;          // cycles since auto mode was switched on
    logic [31:0] m_ts;
    logic [31:0] m_ts_shadow;
    bit          m_fire;
    int          cyc = 0;        // posedges seen, never reset
    int          ctrl_wr_edge = -1;
    logic [31:0] ctrl_wr_data = '0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) m_shadow[i] = '0;
            m_snap_cnt  = '0;
            m_auto_en   = 1'b0;
            m_age       = 0;
            m_ts        = '0;
            m_ts_shadow = '0;
        end else begin
            m_fire = ((cyc == ctrl_wr_edge) && ctrl_wr_data[0]) ||
                     (m_auto_en && ((m_age % PERIOD) == PERIOD - 1));
            if (m_fire) begin
                for (int i = 0; i < NUM_CH; i++) m_shadow[i] = user_data[i*32 +: 32];
                m_snap_cnt  = m_snap_cnt + 16'd1;
                m_ts_shadow = m_ts;
            end
            m_ts = m_ts + 32'd1;
            m_age = m_auto_en ? m_age + 1 : 0;
            if (cyc == ctrl_wr_edge) m_auto_en = ctrl_wr_data[1];
        end
    end

    function automatic logic [31:0] expected_read(input int off);
        if (off == 0) return {m_snap_cnt, 14'd0, m_auto_en, 1'b0};
        if (off == 1) begin
`ifdef REG_BANK_TIMESTAMP_EN
            return m_ts_shadow;
`else
            return 32'd0;
`endif
        end
        if (off >= 2 && off < 2 + NUM_CH) return m_shadow[off-2];
        return 32'd0;
    endfunction

    // ---------------- bus tasks ----------------
    task automatic bus_xfer(input string tag, input logic [31:0] addr, input bit rnw,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata);
        bit is_hit;
        int off;
        bit ack_seen;
        is_hit = (addr >= BASE) && (addr <= HIGH);
        off    = int'((addr - BASE) >> 2);
        @(negedge clk);
        opb_abus   = addr;
        opb_rnw    = rnw;
        opb_dbus   = rnw ? 32'd0 : wdata;
        opb_be     = be;
        opb_select = 1'b1;
        @(negedge clk);
        rdata = sl_dbus;
        if (is_hit) begin
            check({tag, "_ack"}, 32'(sl_xferack), 32'd1);
            if (rnw) begin
                check({tag, "_rdata"}, sl_dbus, expected_read(off));
            end else begin
                check({tag, "_wr_dbus"}, sl_dbus, 32'd0);
                // BE value bit 0 is OPB_BE[3]
                if (off == 0 && be[0]) begin
                    ctrl_wr_edge = cyc + 1;
                    ctrl_wr_data = wdata;
                end
            end
            opb_select = 1'b0;
            @(negedge clk);
            check({tag, "_ack_once"}, 32'(sl_xferack), 32'd0);
            check({tag, "_dbus_idle"}, sl_dbus, 32'd0);
        end else begin
            ack_seen = sl_xferack;
            repeat (3) begin
                @(negedge clk);
                ack_seen |= sl_xferack;
            end
            opb_select = 1'b0;
            check({tag, "_no_ack"}, 32'(ack_seen), 32'd0);
        end
    endtask

    task automatic rd(input string tag, input int off, output logic [31:0] data);
        bus_xfer(tag, BASE + 32'(off * 4), 1'b1, 32'd0, 4'hF, data);
    endtask

    task automatic wr(input string tag, input int off, input logic [31:0] data, input logic [3:0] be);
        logic [31:0] dummy;
        bus_xfer(tag, BASE + 32'(off * 4), 1'b0, data, be, dummy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d;
        logic [15:0] s0;
        int          r;
        int          off;

        repeat (3) @(negedge clk);
        check("rst_ack",     32'(sl_xferack), 32'd0);
        check("rst_dbus",    sl_dbus, 32'd0);
        check("rst_tied",    32'({sl_errack, sl_retry, sl_toutsup}), 32'd0);
        rst_n = 1'b1;

        rd("rd_ctrl_reset", 0, d);
        check("ctrl_reset_const", d, 32'h0000_0000);
        check("idle_dbus", sl_dbus, 32'd0);

        // software snapshot
        user_data[0*32 +: 32] = 32'hDEAD_BEEF;
        user_data[3*32 +: 32] = 32'h1234_5678;
        wr("sw_snap", 0, 32'h1, 4'hF);
        rd("rd_ch0", 2, d);
        check("ch0_const", d, 32'hDEAD_BEEF);
        rd("rd_ch3", 5, d);
        check("ch3_const", d, 32'h1234_5678);
        rd("rd_ctrl_cnt1", 0, d);
        check("ctrl_cnt1_const", d, 32'h0001_0000);

        // shadows hold without a snapshot; BE[3]=0 write is ignored
        user_data = '1;
        rd("rd_ch0_hold", 2, d);
        check("ch0_hold_const", d, 32'hDEAD_BEEF);
        wr("ctrl_be0", 0, 32'h1, 4'h0);
        rd("rd_ctrl_be0", 0, d);
        check("ctrl_be0_const", d, 32'h0001_0000);

        // out-of-range offsets, read-only shadows, misses
        rd("rd_off6", 2 + NUM_CH, d);
        check("off6_const", d, 32'd0);
        rd("rd_high", 63, d);
        wr("wr_ch0", 2, 32'hAAAA_5555, 4'hF);
        rd("rd_ch0_ro", 2, d);
        check("ch0_ro_const", d, 32'hDEAD_BEEF);
        bus_xfer("miss_above", HIGH + 32'd1, 1'b1, 32'd0, 4'hF, d);
        bus_xfer("miss_below", BASE - 32'd4, 1'b1, 32'd0, 4'hF, d);

        // timestamp / reserved word
        rd("rd_ts", 1, d);
`ifndef REG_BANK_TIMESTAMP_EN
        check("ts_absent_const", d, 32'd0);
`endif

        // auto mode: 10 snapshots in 80 cycles, then stop
        s0 = m_snap_cnt;
        wr("auto_on", 0, 32'h2, 4'hF);
        repeat (80) @(negedge clk);
        rd("rd_auto80", 0, d);
        check("auto80_cnt", 32'(d[31:16]), 32'(s0 + 16'd10));
        wr("auto_off", 0, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        s0 = m_snap_cnt;
        repeat (40) @(negedge clk);
        rd("rd_auto_stopped", 0, d);
        check("auto_stopped_cnt", 32'(d[31:16]), 32'(s0));

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1: for (int i = 0; i < NUM_CH; i++) user_data[i*32 +: 32] = $urandom();
                2, 3, 4, 5: begin
                    off = $urandom_range(0, 7);
                    if ($urandom_range(0, 9) == 0) off = 63;
                    rd("rnd_rd", off, d);
                end
                6: wr("rnd_ctrl", 0, 32'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
                7: wr("rnd_wr", $urandom_range(1, 7), $urandom(), 4'hF);
                8: repeat ($urandom_range(0, 12)) @(negedge clk);
                default: rd("rnd_ctrl_rd", 0, d);
            endcase
        end

        // reset in the middle of a transfer: no ack
        wr("pre_rst_auto_off", 0, 32'h0, 4'hF);
        @(negedge clk);
        opb_abus   = BASE;
        opb_rnw    = 1'b1;
        opb_be     = 4'hF;
        opb_select = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ack",  32'(sl_xferack), 32'd0);
        check("rst_mid_dbus", sl_dbus, 32'd0);
        opb_select = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd("rd_ctrl_after_rst", 0, d);
        check("ctrl_after_rst_const", d, 32'd0);
        rd("rd_ch0_after_rst", 2, d);
        check("ch0_after_rst_const", d, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
